mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch path and the load/store path of the RV32I core.
- Arbitrates between the two requesters and issues the memory access.
- Tracks one outstanding read for a fixed memory latency and routes the read data back to its owner.
- Fetch stalls are visible to the PC logic through `if_stall`.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from an accepted read (mem_en=1, mem_we=0) to a valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid, one cycle
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  if_req & ~if_gnt
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid, one cycle; loads only
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read

Behaviour:
- Reset:
  - Asynchronous; state=IDLE, cnt=0, owner=REQ_IF, last_gnt=REQ_D.
  - All outputs are 0 while rst=1: gnts, rvalids, mem_en, mem_we, if_stall, mem_addr, mem_wdata and both rdata buses.
- Register states:
  - IDLE: no read in flight.
  - WAIT: read in flight, cnt counts cycles since its grant.
- Grant availability: a grant may be issued in cycle C iff one of:
  - state=IDLE, or
  - state=WAIT and cnt==MEM_LAT-1, i.e. the response cycle, which allows back-to-back reads.
- Grant selection, combinational in the same cycle as the request:
  - only one requester active -> grant it;
  - both active -> grant the one not equal to last_gnt (round-robin);
  - at most one grant per cycle.
- On a grant:
  - mem_en=1, mem_we=d_we (0 for fetch), mem_addr/mem_wdata from the winner; mem_wdata=0 for fetch;
  - last_gnt <= winner.
- Store grant: completes in the grant cycle, no rvalid. If issued from IDLE, state stays IDLE.
- Read grant: state <= WAIT, cnt <= 0, owner <= winner.
- In WAIT: cnt increments each cycle. In the cycle cnt==MEM_LAT-1 (response cycle):
  - assert the rvalid of `owner` for exactly that cycle;
  - that rdata = mem_rdata (combinational pass-through);
  - the other rvalid stays 0.
- Leaving the response cycle:
  - a new read granted in it -> state stays WAIT, cnt <= 0, owner <= new winner;
  - otherwise state <= IDLE (a store granted in it also leads to IDLE).
- MEM_LAT=1: state never holds WAIT longer than one cycle; sustained one read per cycle.
- rdata buses drive 0 when their rvalid=0.
- if_stall = if_req & ~if_gnt at all times, including during WAIT.
- Starvation: under continuous contention grants alternate IF, D, IF, D…; neither requester waits more than one grant slot beyond the in-flight read.
- Reset mid-read: the outstanding read is dropped; no rvalid is issued after rst deasserts.
- A requester dropping req before gnt is a protocol violation; the arbiter simply re-evaluates each cycle.

Decomposition:
- Shared package (core_pkg):
  - req_id_t enum: REQ_IF=0, REQ_D=1
  - arb_state_t enum: IDLE, WAIT
  - constant MEM_LAT_MAX=7
  - cnt width = 3 bits
- Sub-module rr_arb2: 2-input round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0], winner.
  - Purely combinational.
- The top module holds the FSM, counter, owner/last_gnt registers and the datapath muxes.

Test Plan:
- Reset (MEM_LAT=2): rst high for 3 cycles with if_req=1, d_req=1 -> all outputs 0. First cycle after release -> if_gnt=1, d_gnt=0 (last_gnt=REQ_D).
- Single fetch, if_addr=0x10, memory returning 0x00500093 -> if_gnt in cycle T; if_rvalid=1 with if_rdata=0x00500093 in T+2 only; d_rvalid=0 throughout.
- Contention, both requesting reads continuously -> grants alternate IF, D, IF, D at T, T+2, T+4, T+6; each rvalid goes to the correct owner; if_stall=1 in the cycles IF is not granted.
- Store back-to-back with fetch, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF while idle -> mem_en=mem_we=1 with that address/data in the grant cycle; no d_rvalid. A fetch pending in the next cycle is granted immediately.
- MEM_LAT=1 streaming: 4 consecutive fetches 0x0, 0x4, 0x8, 0xC -> one grant per cycle; if_rvalid high for 4 consecutive cycles, each one cycle after its grant.
- Reset mid-read: grant a load, assert rst in T+1 and release in T+3 -> no d_rvalid ever; state IDLE; the next request is granted in the first post-reset cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the memory port arbiter.
package core_pkg;

   // Requester identity; also the value stored in owner/last_gnt.
   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   // Arbiter FSM: IDLE = no read in flight, WAIT = read in flight.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_t;

   // Largest supported memory read latency and the counter width that covers it.
   localparam int MEM_LAT_MAX = 7;
   localparam int CNT_W       = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. When both inputs request, the one that did
// not win last time is chosen; a lone request always wins.
module rr_arb2
   import core_pkg::*;
(
   input  logic    [1:0] req,
   input  req_id_t       last,
   output logic    [1:0] gnt,
   output req_id_t       winner
);

   // Pick the winner and form a one-hot grant (all zero when nobody asks).
   always_comb begin
      gnt    = 2'b00;
      winner = REQ_IF;
      if (req == 2'b11) begin
         winner = (last == REQ_IF) ? REQ_D : REQ_IF;
      end else if (req[1]) begin
         winner = REQ_D;
      end else begin
         winner = REQ_IF;
      end
      if (req != 2'b00) begin
         gnt = (winner == REQ_D) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Grants are combinational in the request cycle; one read may be in flight
// and its data is routed back to its owner exactly MEM_LAT cycles later.
// A new grant is allowed in the response cycle so reads can stream.
// Valid MEM_LAT range is 1..MEM_LAT_MAX.
//
// Handshake: a requester raises req with its address/data and holds them
// stable until it sees gnt high in the same cycle; the access is accepted in
// that cycle. rvalid is a single-cycle pulse with no back-pressure.
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output arb_state_t        dbg_state
);

   localparam logic [CNT_W-1:0] RESP_CNT = CNT_W'(MEM_LAT - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_id_t          owner_q, owner_d;
   req_id_t          last_gnt_q, last_gnt_d;

   logic             resp_cycle;
   logic             gnt_avail;
   logic [1:0]       req_vec;
   logic [1:0]       gnt_vec;
   req_id_t          winner;
   logic             rd_gnt;

   // The cycle in which the in-flight read's data is on mem_rdata.
   assign resp_cycle = (state_q == WAIT) && (cnt_q == RESP_CNT);
   // Memory port is free when idle or when the pending read completes now.
   assign gnt_avail  = ~rst & ((state_q == IDLE) | resp_cycle);
   assign req_vec    = {d_req, if_req} & {2{gnt_avail}};

   rr_arb2 u_rr_arb2 (
      .req    (req_vec),
      .last   (last_gnt_q),
      .gnt    (gnt_vec),
      .winner (winner)
   );

   assign if_gnt    = gnt_vec[0];
   assign d_gnt     = gnt_vec[1];
   assign if_stall  = ~rst & if_req & ~gnt_vec[0];

   assign mem_en    = |gnt_vec;
   assign mem_we    = gnt_vec[1] & d_we;
   assign mem_addr  = gnt_vec[1] ? d_addr : (gnt_vec[0] ? if_addr : '0);
   assign mem_wdata = gnt_vec[1] ? d_wdata : '0;
   assign rd_gnt    = mem_en & ~mem_we;

   assign if_rvalid = ~rst & resp_cycle & (owner_q == REQ_IF);
   assign d_rvalid  = ~rst & resp_cycle & (owner_q == REQ_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;

   assign dbg_state = state_q;

   // Next-state: a read grant (re)starts the wait, otherwise the response
   // cycle returns to IDLE and the counter ages the in-flight read.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      if (mem_en) begin
         last_gnt_d = winner;
      end
      if (rd_gnt) begin
         state_d = WAIT;
         cnt_d   = '0;
         owner_d = winner;
      end else if (resp_cycle) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; reset drops any outstanding read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         owner_q    <= REQ_IF;
         last_gnt_q <= REQ_D;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=2 and one with
// MEM_LAT=1, a memory emulator per instance, a cycle-level behavioural model
// and directed scenarios followed by randomized traffic.
module tb_mem_port_arbiter;
   import core_pkg::*;

   logic        clk;
   logic        rst;
   int          cyc;
   int          total;
   int          bad;

   logic        if_req_s    [2];
   logic [31:0] if_addr_s   [2];
   logic        if_gnt_s    [2];
   logic        if_rvalid_s [2];
   logic [31:0] if_rdata_s  [2];
   logic        if_stall_s  [2];
   logic        d_req_s     [2];
   logic        d_we_s      [2];
   logic [31:0] d_addr_s    [2];
   logic [31:0] d_wdata_s   [2];
   logic        d_gnt_s     [2];
   logic        d_rvalid_s  [2];
   logic [31:0] d_rdata_s   [2];
   logic        mem_en_s    [2];
   logic        mem_we_s    [2];
   logic [31:0] mem_addr_s  [2];
   logic [31:0] mem_wdata_s [2];
   logic [31:0] mem_rdata_s [2];
   arb_state_t  dbg_state_s [2];

   // Memory emulator contents and read-return schedule (slot = cycle % 8).
   logic [31:0] mem      [2][64];
   logic        sched_v  [2][8];
   logic [31:0] sched_d  [2][8];

   // Behavioural model: one in-flight read described by its due cycle.
   logic        m_busy  [2];
   int          m_due   [2];
   logic        m_owner [2];   // 0 = fetch, 1 = data
   logic [31:0] m_data  [2];
   logic        m_last  [2];   // 0 = fetch, 1 = data
   logic        acc_i   [2];
   logic        acc_d   [2];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
      .clk(clk), .rst(rst),
      .if_req(if_req_s[0]), .if_addr(if_addr_s[0]), .if_gnt(if_gnt_s[0]),
      .if_rvalid(if_rvalid_s[0]), .if_rdata(if_rdata_s[0]), .if_stall(if_stall_s[0]),
      .d_req(d_req_s[0]), .d_we(d_we_s[0]), .d_addr(d_addr_s[0]), .d_wdata(d_wdata_s[0]),
      .d_gnt(d_gnt_s[0]), .d_rvalid(d_rvalid_s[0]), .d_rdata(d_rdata_s[0]),
      .mem_en(mem_en_s[0]), .mem_we(mem_we_s[0]), .mem_addr(mem_addr_s[0]),
      .mem_wdata(mem_wdata_s[0]), .mem_rdata(mem_rdata_s[0]), .dbg_state(dbg_state_s[0])
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req_s[1]), .if_addr(if_addr_s[1]), .if_gnt(if_gnt_s[1]),
      .if_rvalid(if_rvalid_s[1]), .if_rdata(if_rdata_s[1]), .if_stall(if_stall_s[1]),
      .d_req(d_req_s[1]), .d_we(d_we_s[1]), .d_addr(d_addr_s[1]), .d_wdata(d_wdata_s[1]),
      .d_gnt(d_gnt_s[1]), .d_rvalid(d_rvalid_s[1]), .d_rdata(d_rdata_s[1]),
      .mem_en(mem_en_s[1]), .mem_we(mem_we_s[1]), .mem_addr(mem_addr_s[1]),
      .mem_wdata(mem_wdata_s[1]), .mem_rdata(mem_rdata_s[1]), .dbg_state(dbg_state_s[1])
   );

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle counter and memory read-data driver (garbage when nothing is due).
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (sched_v[k][cyc % 8]) begin
            mem_rdata_s[k]      = sched_d[k][cyc % 8];
            sched_v[k][cyc % 8] = 1'b0;
         end else begin
            mem_rdata_s[k] = $urandom;
         end
      end
   end

   // Compare process: model each instance per cycle, check, then emulate memory.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         string       p;
         logic        resp;
         logic        avail;
         logic        gi;
         logic        gd;
         logic        e_ivalid;
         logic        e_dvalid;
         logic [31:0] e_addr;
         p = $sformatf("k%0d c%0d", k, cyc);
         if (rst) begin
            check({p, " rst if_gnt"}, 32'(if_gnt_s[k]), 0);
            check({p, " rst d_gnt"}, 32'(d_gnt_s[k]), 0);
            check({p, " rst if_rvalid"}, 32'(if_rvalid_s[k]), 0);
            check({p, " rst d_rvalid"}, 32'(d_rvalid_s[k]), 0);
            check({p, " rst mem_en"}, 32'(mem_en_s[k]), 0);
            check({p, " rst mem_we"}, 32'(mem_we_s[k]), 0);
            check({p, " rst if_stall"}, 32'(if_stall_s[k]), 0);
            check({p, " rst mem_addr"}, mem_addr_s[k], 0);
            check({p, " rst mem_wdata"}, mem_wdata_s[k], 0);
            check({p, " rst if_rdata"}, if_rdata_s[k], 0);
            check({p, " rst d_rdata"}, d_rdata_s[k], 0);
            m_busy[k] = 1'b0;
            m_last[k] = 1'b1;
            acc_i[k]  = 1'b0;
            acc_d[k]  = 1'b0;
         end else begin
            resp  = m_busy[k] && (m_due[k] == cyc);
            avail = !m_busy[k] || resp;
            gi = 1'b0;
            gd = 1'b0;
            if (avail) begin
               if (if_req_s[k] && d_req_s[k]) begin
                  if (m_last[k]) gi = 1'b1;
                  else           gd = 1'b1;
               end else begin
                  gi = if_req_s[k];
                  gd = d_req_s[k];
               end
            end
            e_ivalid = resp && (m_owner[k] == 1'b0);
            e_dvalid = resp && (m_owner[k] == 1'b1);
            e_addr   = gd ? d_addr_s[k] : if_addr_s[k];
            check({p, " if_gnt"}, 32'(if_gnt_s[k]), 32'(gi));
            check({p, " d_gnt"}, 32'(d_gnt_s[k]), 32'(gd));
            check({p, " mem_en"}, 32'(mem_en_s[k]), 32'(gi | gd));
            check({p, " mem_we"}, 32'(mem_we_s[k]), 32'(gd & d_we_s[k]));
            check({p, " if_stall"}, 32'(if_stall_s[k]), 32'(if_req_s[k] & ~gi));
            if (gi | gd) begin
               check({p, " mem_addr"}, mem_addr_s[k], e_addr);
               check({p, " mem_wdata"}, mem_wdata_s[k], gd ? d_wdata_s[k] : 32'h0);
            end
            check({p, " if_rvalid"}, 32'(if_rvalid_s[k]), 32'(e_ivalid));
            check({p, " d_rvalid"}, 32'(d_rvalid_s[k]), 32'(e_dvalid));
            check({p, " if_rdata"}, if_rdata_s[k], e_ivalid ? m_data[k] : 32'h0);
            check({p, " d_rdata"}, d_rdata_s[k], e_dvalid ? m_data[k] : 32'h0);
            if (resp) m_busy[k] = 1'b0;
            if (gi | gd) begin
               m_last[k] = gd;
               if (gi || !d_we_s[k]) begin
                  m_busy[k]  = 1'b1;
                  m_due[k]   = cyc + lat_of(k);
                  m_owner[k] = gd;
                  m_data[k]  = mem[k][e_addr[7:2]];
               end
            end
            acc_i[k] = gi;
            acc_d[k] = gd;
         end
         if (mem_en_s[k] && !mem_we_s[k]) begin
            sched_v[k][(cyc + lat_of(k)) % 8] = 1'b1;
            sched_d[k][(cyc + lat_of(k)) % 8] = mem[k][mem_addr_s[k][7:2]];
         end
         if (mem_en_s[k] && mem_we_s[k]) begin
            mem[k][mem_addr_s[k][7:2]] = mem_wdata_s[k];
         end
      end
   end

   // Directed scenarios, then random traffic, then the report.
   initial begin
      cyc   = 0;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if_req_s[k] = 0; if_addr_s[k] = 0; d_req_s[k] = 0; d_we_s[k] = 0;
         d_addr_s[k] = 0; d_wdata_s[k] = 0; mem_rdata_s[k] = 0;
         m_busy[k] = 0; m_due[k] = 0; m_owner[k] = 0; m_data[k] = 0; m_last[k] = 1;
         acc_i[k] = 0; acc_d[k] = 0;
         for (int s = 0; s < 8; s++) begin sched_v[k][s] = 0; sched_d[k][s] = 0; end
         for (int w = 0; w < 64; w++) mem[k][w] = $urandom;
      end
      mem[0][4]  = 32'h0050_0093;
      mem[0][8]  = 32'h1111_2222;
      mem[0][12] = 32'h3333_4444;
      for (int w = 0; w < 4; w++) mem[1][w] = 32'hA000_0000 + 32'(w);

      // Reset with both requesting, then continuous contention.
      if_req_s[0] = 1; if_addr_s[0] = 32'h20;
      d_req_s[0]  = 1; d_we_s[0] = 0; d_addr_s[0] = 32'h30;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset if_gnt", 32'(if_gnt_s[0]), 0);
         check("reset mem_en", 32'(mem_en_s[0]), 0);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         @(negedge clk);
         check($sformatf("contend%0d if_gnt", i), 32'(if_gnt_s[0]), 32'(i % 4 == 0));
         check($sformatf("contend%0d d_gnt", i), 32'(d_gnt_s[0]), 32'(i % 4 == 2));
         check($sformatf("contend%0d if_stall", i), 32'(if_stall_s[0]), 32'(i % 4 != 0));
         check($sformatf("contend%0d if_rvalid", i), 32'(if_rvalid_s[0]), 32'(i >= 2 && i % 4 == 2));
         check($sformatf("contend%0d d_rvalid", i), 32'(d_rvalid_s[0]), 32'(i >= 4 && i % 4 == 0));
         if (i == 2) check("contend if_rdata", if_rdata_s[0], 32'h1111_2222);
         if (i == 4) check("contend d_rdata", d_rdata_s[0], 32'h3333_4444);
      end
      step();
      if_req_s[0] = 0; d_req_s[0] = 0;
      repeat (3) step();

      // Single fetch.
      if_req_s[0] = 1; if_addr_s[0] = 32'h10;
      @(negedge clk);
      check("fetch if_gnt", 32'(if_gnt_s[0]), 1);
      for (int j = 1; j < 4; j++) begin
         step();
         if_req_s[0] = 0;
         @(negedge clk);
         check($sformatf("fetch+%0d if_rvalid", j), 32'(if_rvalid_s[0]), 32'(j == 2));
         check($sformatf("fetch+%0d d_rvalid", j), 32'(d_rvalid_s[0]), 0);
         if (j == 2) check("fetch if_rdata", if_rdata_s[0], 32'h0050_0093);
      end

      // Store while idle, then a fetch of the same word right behind it.
      step();
      d_req_s[0] = 1; d_we_s[0] = 1; d_addr_s[0] = 32'h40; d_wdata_s[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      check("store d_gnt", 32'(d_gnt_s[0]), 1);
      check("store mem_en", 32'(mem_en_s[0]), 1);
      check("store mem_we", 32'(mem_we_s[0]), 1);
      check("store mem_addr", mem_addr_s[0], 32'h40);
      check("store mem_wdata", mem_wdata_s[0], 32'hDEAD_BEEF);
      step();
      d_req_s[0] = 0; d_we_s[0] = 0;
      if_req_s[0] = 1; if_addr_s[0] = 32'h40;
      @(negedge clk);
      check("store_fetch if_gnt", 32'(if_gnt_s[0]), 1);
      check("store_fetch d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      if_req_s[0] = 0;
      @(negedge clk);
      check("store_fetch+1 d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      @(negedge clk);
      check("store_fetch+2 if_rvalid", 32'(if_rvalid_s[0]), 1);
      check("store_fetch+2 if_rdata", if_rdata_s[0], 32'hDEAD_BEEF);
      step();

      // Reset in the middle of a load.
      d_req_s[0] = 1; d_we_s[0] = 0; d_addr_s[0] = 32'h10;
      @(negedge clk);
      check("rstmid d_gnt", 32'(d_gnt_s[0]), 1);
      step();
      d_req_s[0] = 0;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid+1 d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      @(negedge clk);
      check("rstmid+2 d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      rst = 1'b0;
      if_req_s[0] = 1; if_addr_s[0] = 32'h20;
      @(negedge clk);
      check("rstmid+3 state", 32'(dbg_state_s[0]), 32'(IDLE));
      check("rstmid+3 if_gnt", 32'(if_gnt_s[0]), 1);
      check("rstmid+3 d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      if_req_s[0] = 0;
      @(negedge clk);
      check("rstmid+4 state", 32'(dbg_state_s[0]), 32'(WAIT));
      check("rstmid+4 d_rvalid", 32'(d_rvalid_s[0]), 0);
      step();
      @(negedge clk);
      check("rstmid+5 if_rvalid", 32'(if_rvalid_s[0]), 1);
      check("rstmid+5 if_rdata", if_rdata_s[0], 32'h1111_2222);
      check("rstmid+5 d_rvalid", 32'(d_rvalid_s[0]), 0);

      // MEM_LAT=1 streaming fetches.
      step();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         if (i < 4) begin
            if_req_s[1] = 1; if_addr_s[1] = 32'(i * 4);
         end else begin
            if_req_s[1] = 0;
         end
         @(negedge clk);
         check($sformatf("stream%0d if_gnt", i), 32'(if_gnt_s[1]), 32'(i < 4));
         check($sformatf("stream%0d if_rvalid", i), 32'(if_rvalid_s[1]), 32'(i >= 1));
         if (i >= 1) check($sformatf("stream%0d if_rdata", i), if_rdata_s[1], 32'hA000_0000 + 32'(i - 1));
         if (i == 2) check("stream state", 32'(dbg_state_s[1]), 32'(WAIT));
      end

      // Random traffic on both instances, requests held until granted.
      for (int n = 0; n < 3000; n++) begin
         step();
         rst = (!rst && $urandom_range(0, 599) == 0);
         for (int k = 0; k < 2; k++) begin
            if (if_req_s[k] && acc_i[k]) if_req_s[k] = 0;
            if (!if_req_s[k] && $urandom_range(0, 3) != 0) begin
               if_req_s[k]  = 1;
               if_addr_s[k] = 32'($urandom_range(0, 63)) << 2;
            end
            if (d_req_s[k] && acc_d[k]) d_req_s[k] = 0;
            if (!d_req_s[k] && $urandom_range(0, 2) != 0) begin
               d_req_s[k]   = 1;
               d_we_s[k]    = ($urandom_range(0, 2) == 0);
               d_addr_s[k]  = 32'($urandom_range(0, 63)) << 2;
               d_wdata_s[k] = $urandom;
            end
         end
         @(negedge clk);
      end

      step();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if_req_s[k] = 0;
         d_req_s[k]  = 0;
      end
      repeat (5) step();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
